// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between two requesters; an access holds the port for LATENCY cycles.
// The done pulse and rdata_o follow one cycle later; requests that arrive while BUSY are ignored (no queueing).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic                sel_q, last_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic                we_q;
    logic                done0_q, done1_q;

    logic                start, win, finish;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        win     = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not go last wins; otherwise the lone requester.
                if (req0_i && req1_i) begin
                    win = ~last_q;
                end else begin
                    win = req1_i;
                end
                if (req0_i || req1_i) begin
                    start   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done0_q <= finish && !sel_q;
            done1_q <= finish && sel_q;
            if (start) begin
                sel_q   <= win;
                last_q  <= win;
                cnt_q   <= CNT_INIT;
                addr_q  <= win ? addr1_i  : addr0_i;
                wdata_q <= win ? wdata1_i : wdata0_i;
                we_q    <= win ? we1_i    : we0_i;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (finish && !we_q) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Every output is a register or a decode of registered state.
    assign gnt0_o      = (state_q == BUSY) && !sel_q;
    assign gnt1_o      = (state_q == BUSY) && sel_q;
    assign mem_en_o    = (state_q == BUSY);
    assign mem_we_o    = (state_q == BUSY) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LATENCY 2, 3, 1) share the same stimulus;
// each test checks only the instance whose latency it targets.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

    logic        gnt0 [3];
    logic        gnt1 [3];
    logic        done0 [3];
    logic        done1 [3];
    logic        mem_en [3];
    logic        mem_we [3];
    logic [31:0] rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .we0_i(we0), .we1_i(we1), .gnt0_o(gnt0[0]), .gnt1_o(gnt1[0]),
        .done0_o(done0[0]), .done1_o(done1[0]), .rdata_o(rdata[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .we0_i(we0), .we1_i(we1), .gnt0_o(gnt0[1]), .gnt1_o(gnt1[1]),
        .done0_o(done0[1]), .done1_o(done1[1]), .rdata_o(rdata[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .req0_i(req0), .req1_i(req1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .we0_i(we0), .we1_i(we1), .gnt0_o(gnt0[2]), .gnt1_o(gnt1[2]),
        .done0_o(done0[2]), .done1_o(done1[2]), .rdata_o(rdata[2]),
        .mem_en_o(mem_en[2]), .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]),
        .mem_wdata_o(mem_wdata[2]), .mem_rdata_i(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so inputs change and outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
        do_reset();

        // Reset state (LATENCY=2 instance)
        check("rst_gnt0", gnt0[0], 0);
        check("rst_gnt1", gnt1[0], 0);
        check("rst_en", mem_en[0], 0);
        check("rst_done", {done0[0], done1[0]}, 0);
        check("rst_rdata", rdata[0], 0);
        check("rst_addr", mem_addr[0], 0);
        check("rst_wdata", mem_wdata[0], 0);

        // Tie from reset: 6 alternating accesses, port 0 first
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
        mem_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("tie_gnt0", gnt0[0], (k % 2 == 0));
            check("tie_gnt1", gnt1[0], (k % 2 == 1));
            check("tie_addr", mem_addr[0], (k % 2 == 0) ? 32'h100 : 32'h200);
            check("tie_done_low", {done0[0], done1[0]}, 0);
            tick();
            if (k == 5) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
            check("tie_done0", done0[0], (k % 2 == 0));
            check("tie_done1", done1[0], (k % 2 == 1));
            check("tie_gnt_gap", {gnt0[0], gnt1[0]}, 0);
        end
        tick();
        check("tie_idle_en", mem_en[0], 0);

        // Single read
        req0 = 1'b1; addr0 = 32'h40; we0 = 1'b0; mem_rdata = 32'hDEADBEEF;
        tick();
        req0 = 1'b0;
        check("rd_gnt0_c1", gnt0[0], 1);
        check("rd_en_c1", mem_en[0], 1);
        check("rd_addr_c1", mem_addr[0], 32'h40);
        check("rd_we_c1", mem_we[0], 0);
        tick();
        check("rd_gnt0_c2", gnt0[0], 1);
        check("rd_en_c2", mem_en[0], 1);
        tick();
        check("rd_done0", done0[0], 1);
        check("rd_rdata", rdata[0], 32'hDEADBEEF);
        check("rd_gnt0_off", gnt0[0], 0);
        check("rd_en_off", mem_en[0], 0);
        tick();
        check("rd_done0_1cyc", done0[0], 0);
        check("rd_rdata_hold", rdata[0], 32'hDEADBEEF);

        // Write on port 1: rdata_o must not change
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'h1234;
        mem_rdata = 32'h55555555;
        tick();
        req1 = 1'b0; we1 = 1'b0; wdata1 = 32'h0;
        check("wr_gnt1", gnt1[0], 1);
        check("wr_we_c1", mem_we[0], 1);
        check("wr_addr", mem_addr[0], 32'h80);
        check("wr_wdata_c1", mem_wdata[0], 32'h1234);
        tick();
        check("wr_we_c2", mem_we[0], 1);
        check("wr_wdata_c2", mem_wdata[0], 32'h1234);
        tick();
        check("wr_done1", done1[0], 1);
        check("wr_rdata_kept", rdata[0], 32'hDEADBEEF);
        check("wr_we_off", mem_we[0], 0);
        check("wr_wdata_hold", mem_wdata[0], 32'h1234);
        tick();

        // Latching: address change mid-BUSY is ignored
        req0 = 1'b1; addr0 = 32'h10;
        tick();
        check("lat_addr_c1", mem_addr[0], 32'h10);
        req0 = 1'b0; addr0 = 32'h20;
        tick();
        check("lat_addr_c2", mem_addr[0], 32'h10);
        check("lat_gnt0_c2", gnt0[0], 1);
        tick();
        check("lat_done0", done0[0], 1);
        check("lat_addr_hold", mem_addr[0], 32'h10);

        // Reset in the 2nd BUSY cycle (LATENCY=3 instance)
        do_reset();
        req0 = 1'b1; addr0 = 32'h44; mem_rdata = 32'h11111111;
        tick();
        req0 = 1'b0;
        check("rmb_gnt0_c1", gnt0[1], 1);
        tick();
        check("rmb_gnt0_c2", gnt0[1], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmb_gnt", {gnt0[1], gnt1[1]}, 0);
        check("rmb_en", mem_en[1], 0);
        check("rmb_addr", mem_addr[1], 0);
        check("rmb_rdata", rdata[1], 0);
        check("rmb_done", {done0[1], done1[1]}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rmb_no_done", {done0[1], done1[1]}, 0);
        end
        req1 = 1'b1; addr1 = 32'h90; we1 = 1'b0; mem_rdata = 32'hCAFEF00D;
        tick();
        req1 = 1'b0;
        check("rmb_p1_gnt1", gnt1[1], 1);
        check("rmb_p1_addr", mem_addr[1], 32'h90);
        tick();
        tick();
        check("rmb_p1_gnt1_c3", gnt1[1], 1);
        tick();
        check("rmb_p1_done1", done1[1], 1);
        check("rmb_p1_rdata", rdata[1], 32'hCAFEF00D);

        // LATENCY=1 with req0 held: one access every 2 cycles
        do_reset();
        req0 = 1'b1; addr0 = 32'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("l1_gnt0_hi", gnt0[2], 1);
            check("l1_done0_lo", done0[2], 0);
            tick();
            check("l1_gnt0_lo", gnt0[2], 0);
            check("l1_done0_hi", done0[2], 1);
        end
        req0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
